// File: rtl/disp_pkg.sv
// Shared types and constants for the display scheduler and its blink timer.
package disp_pkg;

    localparam int NUM_DIGITS      = 4;
    localparam int BLINK_TICKS_DEF = 250;

    typedef enum logic [0:0] {
        BASE = 1'b0,
        SHOW = 1'b1
    } disp_state_t;

    typedef struct packed {
        logic [NUM_DIGITS*4-1:0] hexs;
        logic [NUM_DIGITS-1:0]   points;
    } disp_msg_t;

    // Digits blank only while blinking is enabled and the phase is off.
    function automatic logic [NUM_DIGITS-1:0] blank_lanes(
        input logic                  en,
        input logic                  off,
        input logic [NUM_DIGITS-1:0] mask
    );
        logic [NUM_DIGITS-1:0] res;
        if (en && off) begin
            res = mask;
        end else begin
            res = {NUM_DIGITS{1'b0}};
        end
        return res;
    endfunction

endpackage

// File: rtl/disp_scheduler_if.sv
// Message request/acknowledge handshake between a requester and the display scheduler.
interface disp_scheduler_if
    import disp_pkg::*;
#(
    parameter int HOLD_W = 8
);
    logic                    msg_req;
    logic [NUM_DIGITS*4-1:0] msg_hexs;
    logic [NUM_DIGITS-1:0]   msg_points;
    logic [HOLD_W-1:0]       msg_hold;
    logic                    msg_ack;
    logic                    msg_busy;

    modport master (
        output msg_req, msg_hexs, msg_points, msg_hold,
        input  msg_ack, msg_busy
    );

    modport slave (
        input  msg_req, msg_hexs, msg_points, msg_hold,
        output msg_ack, msg_busy
    );
endinterface

// File: rtl/disp_blink_timer.sv
// Blink time base: counts ticks and toggles the off-phase every BLINK_TICKS ticks.
module disp_blink_timer
    import disp_pkg::*;
#(
    parameter int BLINK_TICKS = BLINK_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic blink_en,
    output logic phase_off
);
    localparam logic [15:0] LAST_CNT = 16'(BLINK_TICKS - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;

    // Next count/phase; disabled blinking parks the timer at the on-phase.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!blink_en) begin
            cnt_d   = 16'd0;
            phase_d = 1'b0;
        end else if (tick) begin
            if (cnt_q >= LAST_CNT) begin
                cnt_d   = 16'd0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + 16'd1;
                phase_d = phase_q;
            end
        end else begin
            cnt_d   = cnt_q;
            phase_d = phase_q;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 16'd0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_off = phase_q;
endmodule

// File: rtl/disp_scheduler.sv
// Display scheduler: shows base digits (with optional blink) or timed messages,
// with a one-entry pending buffer behind the active message.
module disp_scheduler
    import disp_pkg::*;
#(
    parameter int BLINK_TICKS = BLINK_TICKS_DEF,
    parameter int HOLD_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [NUM_DIGITS*4-1:0] base_hexs,
    input  logic [NUM_DIGITS-1:0]   base_points,
    input  logic                    blink_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    disp_scheduler_if.slave         msg,
    output logic [NUM_DIGITS*4-1:0] hexs,
    output logic [NUM_DIGITS-1:0]   points,
    output logic [NUM_DIGITS-1:0]   LEs
);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    disp_state_t             state_q, state_d;
    disp_msg_t               act_q, act_d, pend_q, pend_d, new_msg_s;
    logic                    pend_v_q, pend_v_d;
    logic [HOLD_W-1:0]       hold_q, hold_d, pend_hold_q, pend_hold_d, new_hold_s;
    logic                    ack_q, ack_d, busy_q, busy_d;
    logic [NUM_DIGITS*4-1:0] hexs_q, hexs_d;
    logic [NUM_DIGITS-1:0]   points_q, points_d, les_q, les_d;
    logic                    phase_off_s, req_ok_s, end_s;

    disp_blink_timer #(.BLINK_TICKS(BLINK_TICKS)) u_blink (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .blink_en  (blink_en),
        .phase_off (phase_off_s)
    );

    assign new_msg_s  = {msg.msg_hexs, msg.msg_points};
    assign new_hold_s = (msg.msg_hold == '0) ? HOLD_ONE : msg.msg_hold;
    // Blocking back-to-back acks protects against a requester that holds msg_req too long.
    assign req_ok_s   = msg.msg_req && !ack_q;
    assign end_s      = (state_q == SHOW) && tick && (hold_q <= HOLD_ONE);

    // Next-state, buffer management and registered-output selection.
    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        pend_hold_d = pend_hold_q;
        hold_d      = hold_q;
        ack_d       = 1'b0;
        case (state_q)
            BASE: begin
                if (req_ok_s) begin
                    state_d = SHOW;
                    act_d   = new_msg_s;
                    hold_d  = new_hold_s;
                    ack_d   = 1'b1;
                end else begin
                    state_d = BASE;
                end
            end
            SHOW: begin
                if (end_s && pend_v_q) begin
                    act_d  = pend_q;
                    hold_d = pend_hold_q;
                    if (req_ok_s) begin
                        pend_d      = new_msg_s;
                        pend_hold_d = new_hold_s;
                        ack_d       = 1'b1;
                    end else begin
                        pend_v_d = 1'b0;
                    end
                end else if (end_s) begin
                    if (req_ok_s) begin
                        act_d  = new_msg_s;
                        hold_d = new_hold_s;
                        ack_d  = 1'b1;
                    end else begin
                        state_d = BASE;
                        hold_d  = '0;
                    end
                end else begin
                    if (tick) begin
                        hold_d = hold_q - HOLD_ONE;
                    end else begin
                        hold_d = hold_q;
                    end
                    if (req_ok_s && !pend_v_q) begin
                        pend_d      = new_msg_s;
                        pend_hold_d = new_hold_s;
                        pend_v_d    = 1'b1;
                        ack_d       = 1'b1;
                    end else begin
                        pend_v_d = pend_v_q;
                    end
                end
            end
            default: begin
                state_d  = BASE;
                pend_v_d = 1'b0;
                hold_d   = '0;
            end
        endcase

        if (state_d == SHOW) begin
            hexs_d   = act_d.hexs;
            points_d = act_d.points;
            les_d    = {NUM_DIGITS{1'b0}};
        end else begin
            hexs_d   = base_hexs;
            points_d = base_points;
            les_d    = blank_lanes(blink_en, phase_off_s, blink_mask);
        end
        busy_d = (state_d == SHOW) || pend_v_d;
    end

    // State, message buffers and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BASE;
            act_q       <= '0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            pend_hold_q <= '0;
            hold_q      <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            hexs_q      <= '0;
            points_q    <= '0;
            les_q       <= '0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            pend_hold_q <= pend_hold_d;
            hold_q      <= hold_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            hexs_q      <= hexs_d;
            points_q    <= points_d;
            les_q       <= les_d;
        end
    end

    assign msg.msg_ack  = ack_q;
    assign msg.msg_busy = busy_q;
    assign hexs         = hexs_q;
    assign points       = points_q;
    assign LEs          = les_q;
endmodule

// File: tb/tb_disp_scheduler.sv
// Directed self-checking bench for disp_scheduler (BLINK_TICKS=4, HOLD_W=8).
module tb_disp_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [15:0] base_hexs = 16'h0000;
    logic [3:0]  base_points = 4'h0;
    logic        blink_en = 1'b0;
    logic [3:0]  blink_mask = 4'h0;
    logic [15:0] hexs;
    logic [3:0]  points, LEs;
    int          checks = 0;
    int          errors = 0;

    disp_scheduler_if #(.HOLD_W(8)) mif ();

    disp_scheduler #(.BLINK_TICKS(4), .HOLD_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .base_hexs   (base_hexs),
        .base_points (base_points),
        .blink_en    (blink_en),
        .blink_mask  (blink_mask),
        .msg         (mif),
        .hexs        (hexs),
        .points      (points),
        .LEs         (LEs)
    );

    always #5 clk = ~clk;

    // One clock: inputs applied at a negedge, outputs sampled at the next negedge.
    task automatic cyc(input logic t);
        tick = t;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic set_msg(input logic [15:0] h, input logic [3:0] p, input logic [7:0] hold);
        mif.msg_hexs   = h;
        mif.msg_points = p;
        mif.msg_hold   = hold;
        mif.msg_req    = 1'b1;
    endtask

    task automatic test_reset;
        base_hexs = 16'h1234; base_points = 4'b0101;
        mif.msg_req = 1'b0; mif.msg_hexs = 16'h0; mif.msg_points = 4'h0; mif.msg_hold = 8'd0;
        cyc(1'b0); cyc(1'b0);
        checks++; if (hexs !== 16'h0000) begin errors++; $display("FAIL rst_hexs: got %h expected %h", hexs, 16'h0000); end
        checks++; if (mif.msg_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", mif.msg_busy); end
        checks++; if (mif.msg_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", mif.msg_ack); end
        rst = 1'b0;
        cyc(1'b0);
        checks++; if (hexs !== 16'h1234) begin errors++; $display("FAIL base_hexs: got %h expected %h", hexs, 16'h1234); end
        checks++; if (points !== 4'b0101) begin errors++; $display("FAIL base_points: got %b expected 0101", points); end
        checks++; if (LEs !== 4'b0000) begin errors++; $display("FAIL base_les: got %b expected 0000", LEs); end
    endtask

    task automatic test_blink;
        logic [3:0] exp;
        blink_mask = 4'b0011; blink_en = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            cyc(1'b1); cyc(1'b0);
            exp = (((n / 4) % 2) == 1) ? 4'b0011 : 4'b0000;
            checks++; if (LEs !== exp) begin errors++; $display("FAIL blink_les n=%0d: got %b expected %b", n, LEs, exp); end
        end
        blink_en = 1'b0;
        cyc(1'b0); cyc(1'b0);
        checks++; if (LEs !== 4'b0000) begin errors++; $display("FAIL blink_off: got %b expected 0000", LEs); end
    endtask

    task automatic test_msg;
        set_msg(16'hABCD, 4'b1000, 8'd3);
        cyc(1'b0);
        mif.msg_req = 1'b0;
        checks++; if (mif.msg_ack !== 1'b1) begin errors++; $display("FAIL msg_ack: got %b expected 1", mif.msg_ack); end
        checks++; if (hexs !== 16'hABCD) begin errors++; $display("FAIL msg_hexs: got %h expected %h", hexs, 16'hABCD); end
        checks++; if (mif.msg_busy !== 1'b1) begin errors++; $display("FAIL msg_busy: got %b expected 1", mif.msg_busy); end
        cyc(1'b0);
        checks++; if (mif.msg_ack !== 1'b0) begin errors++; $display("FAIL msg_ack_pulse: got %b expected 0", mif.msg_ack); end
        for (int n = 1; n <= 3; n++) begin
            cyc(1'b1);
            checks++;
            if (hexs !== ((n < 3) ? 16'hABCD : 16'h1234)) begin
                errors++; $display("FAIL msg_hold n=%0d: got %h expected %h", n, hexs, (n < 3) ? 16'hABCD : 16'h1234);
            end
        end
        checks++; if (points !== 4'b0101) begin errors++; $display("FAIL msg_end_points: got %b expected 0101", points); end
        checks++; if (mif.msg_busy !== 1'b0) begin errors++; $display("FAIL msg_end_busy: got %b expected 0", mif.msg_busy); end
    endtask

    task automatic test_pending;
        set_msg(16'h1111, 4'b0001, 8'd2);
        cyc(1'b0); mif.msg_req = 1'b0; cyc(1'b0);
        set_msg(16'h5555, 4'b0010, 8'd1);
        cyc(1'b0);
        checks++; if (mif.msg_ack !== 1'b1) begin errors++; $display("FAIL pend_ack2: got %b expected 1", mif.msg_ack); end
        checks++; if (hexs !== 16'h1111) begin errors++; $display("FAIL pend_active: got %h expected %h", hexs, 16'h1111); end
        mif.msg_req = 1'b0; cyc(1'b0);
        set_msg(16'h9999, 4'b0100, 8'd1);
        cyc(1'b0); cyc(1'b0);
        checks++; if (mif.msg_ack !== 1'b0) begin errors++; $display("FAIL pend_full_noack: got %b expected 0", mif.msg_ack); end
        cyc(1'b1);
        checks++; if (mif.msg_ack !== 1'b0) begin errors++; $display("FAIL pend_full_tick: got %b expected 0", mif.msg_ack); end
        cyc(1'b1);
        mif.msg_req = 1'b0;
        checks++; if (mif.msg_ack !== 1'b1) begin errors++; $display("FAIL promo_ack3: got %b expected 1", mif.msg_ack); end
        checks++; if (hexs !== 16'h5555) begin errors++; $display("FAIL promo_hexs: got %h expected %h", hexs, 16'h5555); end
        checks++; if (points !== 4'b0010) begin errors++; $display("FAIL promo_points: got %b expected 0010", points); end
        cyc(1'b1);
        checks++; if (hexs !== 16'h9999) begin errors++; $display("FAIL third_hexs: got %h expected %h", hexs, 16'h9999); end
        checks++; if (mif.msg_ack !== 1'b0) begin errors++; $display("FAIL third_noack: got %b expected 0", mif.msg_ack); end
        cyc(1'b1);
        checks++; if (hexs !== 16'h1234) begin errors++; $display("FAIL pend_base: got %h expected %h", hexs, 16'h1234); end
        checks++; if (mif.msg_busy !== 1'b0) begin errors++; $display("FAIL pend_busy: got %b expected 0", mif.msg_busy); end
    endtask

    task automatic test_back_to_back;
        set_msg(16'h6666, 4'b0000, 8'd1);
        cyc(1'b0); mif.msg_req = 1'b0; cyc(1'b0);
        set_msg(16'h7777, 4'b1111, 8'd1);
        cyc(1'b1);
        mif.msg_req = 1'b0;
        checks++; if (mif.msg_ack !== 1'b1) begin errors++; $display("FAIL direct_ack: got %b expected 1", mif.msg_ack); end
        checks++; if (hexs !== 16'h7777) begin errors++; $display("FAIL direct_hexs: got %h expected %h", hexs, 16'h7777); end
        cyc(1'b1);
        checks++; if (hexs !== 16'h1234) begin errors++; $display("FAIL direct_end: got %h expected %h", hexs, 16'h1234); end
    endtask

    task automatic test_hold0_reset;
        set_msg(16'h2222, 4'b0000, 8'd0);
        cyc(1'b0); mif.msg_req = 1'b0;
        checks++; if (hexs !== 16'h2222) begin errors++; $display("FAIL hold0_show: got %h expected %h", hexs, 16'h2222); end
        cyc(1'b1);
        checks++; if (hexs !== 16'h1234) begin errors++; $display("FAIL hold0_end: got %h expected %h", hexs, 16'h1234); end
        set_msg(16'h3333, 4'b0000, 8'd5);
        cyc(1'b0); mif.msg_req = 1'b0; cyc(1'b0);
        set_msg(16'h4444, 4'b0000, 8'd5);
        cyc(1'b0); mif.msg_req = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (hexs !== 16'h0000) begin errors++; $display("FAIL rst_mid_hexs: got %h expected %h", hexs, 16'h0000); end
        checks++; if (mif.msg_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", mif.msg_busy); end
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0);
        checks++; if (hexs !== 16'h1234) begin errors++; $display("FAIL rst_rel_hexs: got %h expected %h", hexs, 16'h1234); end
        cyc(1'b1); cyc(1'b1);
        checks++; if (mif.msg_busy !== 1'b0) begin errors++; $display("FAIL rst_discard: got %b expected 0", mif.msg_busy); end
    endtask

    initial begin
        mif.msg_req = 1'b0;
        @(negedge clk);
        test_reset();
        test_blink();
        test_msg();
        test_pending();
        test_back_to_back();
        test_hold0_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/disp_scheduler.md
DISP_SCHEDULER -- requirements
Module: disp_scheduler

Interface
REQ-001 Parameter BLINK_TICKS, default 250, tick strobes per blink half-period (legal range 1..65535).
REQ-002 Parameter HOLD_W, default 8, width of the message hold-time field.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  one-cycle time-base strobe, e.g. 1 ms, from a clock divider.
REQ-006 base_hexs  input  16  four hex digits shown when no message is active.
REQ-007 base_points  input  4  decimal points for the base digits.
REQ-008 blink_en  input  1  enables blinking of base digits.
REQ-009 blink_mask  input  4  base digits that blank during the blink off-phase.
REQ-010 msg_req  input  1  message request; held high until acknowledged.
REQ-011 msg_hexs  input  16  message digits, sampled on acknowledge.
REQ-012 msg_points  input  4  message decimal points, sampled on acknowledge.
REQ-013 msg_hold  input  HOLD_W  message display time in ticks, sampled on acknowledge.
REQ-014 msg_ack  output  1  one-cycle pulse: the message has been captured.
REQ-015 msg_busy  output  1  high while a message is showing or pending.
REQ-016 hexs  output  16  digits to the 4-digit display driver.
REQ-017 points  output  4  decimal points to the display driver.
REQ-018 LEs  output  4  per-digit blank enables to the driver; 1 blanks the digit.

Function
REQ-019 All outputs SHALL be registered, with one clk of latency from the inputs that select them.
REQ-020 The FSM SHALL have two states: BASE and SHOW.
REQ-021 In BASE the block SHALL drive hexs=base_hexs, points=base_points, and LEs=blink_mask when blink_en is high and the phase is off, otherwise LEs=0.
REQ-022 In SHOW the block SHALL drive the captured message digits and points with LEs=0, and SHALL not blink.
REQ-023 Accept from BASE: when msg_req=1, the block SHALL capture the message, pulse msg_ack for one cycle, go to SHOW, and load the hold counter with max(msg_hold,1).
REQ-024 In SHOW the hold counter SHALL decrement on each tick; the message ends on the tick that brings it to 0.
REQ-025 The block SHALL have a one-entry pending buffer.
REQ-026 If msg_req=1 in SHOW while the pending buffer is empty, the block SHALL capture the message into pending and pulse msg_ack.
REQ-027 If msg_req=1 while the pending buffer is full, the block SHALL not acknowledge it; the requester keeps holding.
REQ-028 At message end with pending valid, the block SHALL promote pending into SHOW in the same cycle, reload the hold counter, and clear pending.
REQ-029 At message end with pending empty, the block SHALL return to BASE.
REQ-030 If message end and a new msg_req occur in the same cycle with pending empty, the block SHALL accept the new request directly into SHOW with no BASE cycle.
REQ-031 If message end and a new msg_req occur in the same cycle with pending full, the block SHALL promote pending and capture the new request into the freed pending entry, with msg_ack=1.
REQ-032 msg_ack SHALL never be high on two consecutive cycles; after an ack the requester must drop msg_req for at least one cycle.
REQ-033 msg_busy SHALL equal (state==SHOW) OR pending_valid.
REQ-034 The blink counter SHALL count ticks 0..BLINK_TICKS-1 and, on wrap, toggle the phase; it runs in all states.
REQ-035 When blink_en=0 the blink counter and phase SHALL be held at 0 (on-phase).

Reset
REQ-036 Reset SHALL asynchronously set: state=BASE, pending_valid=0, hold counter=0, blink counter=0, phase=on, hexs=0, points=0, LEs=0, msg_ack=0, msg_busy=0.
REQ-037 Reset asserted mid-message SHALL discard both the active and pending messages.
REQ-038 The first cycle after reset release SHALL show base data.

Structure
REQ-039 Shared package disp_pkg SHALL hold the state enum (BASE, SHOW), the digit-count constant 4, and the BLINK_TICKS default.
REQ-040 The blink counter and phase SHALL be a separate sub-module, disp_blink_timer (inputs clk, rst, tick, blink_en; output phase_off).

Verification
REQ-041 Reset release with base_hexs=16'h1234 and blink_en=0 -> on the next cycle hexs=16'h1234 and LEs=0.
REQ-042 blink_en=1, blink_mask=4'b0011, BLINK_TICKS=4 -> LEs toggles between 0000 and 0011 every 4 ticks.
REQ-043 msg_req with msg_hexs=16'hABCD and msg_hold=3 -> one ack pulse, hexs=ABCD for exactly 3 ticks, then back to base.
REQ-044 Second request (16'h5555) during SHOW, then a third -> second acked immediately, third unacked until the promotion cycle, and messages display in order.
REQ-045 msg_hold=0 -> message shown for 1 tick; rst asserted during SHOW -> outputs 0 immediately and msg_busy=0.
